// File: rtl/ck_sync_fifo.sv
// Single-clock FIFO with any depth, optional first-word-fall-through read port,
// programmable almost-full/empty thresholds, occupancy count, sticky error flags and flush.
module ck_sync_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_SIZE   = 4,
  parameter int unsigned FIFO_ADDR_W = $clog2(FIFO_SIZE),
  parameter int unsigned CNT_W       = $clog2(FIFO_SIZE + 1),
  parameter bit          FWFT        = 1'b0,
  parameter int unsigned AF_LEVEL    = FIFO_SIZE - 1,
  parameter int unsigned AE_LEVEL    = 1
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] dataIn,
  output logic              full,
  output logic              almostFull,
  input  logic              pop,
  output logic [DATA_W-1:0] dataOut,
  output logic              empty,
  output logic              almostEmpty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [FIFO_ADDR_W-1:0] LastPtr = FIFO_ADDR_W'(FIFO_SIZE - 1);
  localparam logic [FIFO_ADDR_W-1:0] PtrOne  = FIFO_ADDR_W'(1);
  localparam logic [CNT_W-1:0]       SizeCnt = CNT_W'(FIFO_SIZE);
  localparam logic [CNT_W-1:0]       AfCnt   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]       AeCnt   = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0]       CntOne  = CNT_W'(1);

  logic [DATA_W-1:0]      mem_q [FIFO_SIZE];
  logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   afull_q, afull_d;
  logic                   aempty_q, aempty_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;

  logic                   push_acc, pop_acc;
  logic [DATA_W-1:0]      rd_word;

  // Flush swallows any push/pop of its cycle, including their error reporting.
  always_comb begin
    push_acc = push & ~full_q & ~flush;
    pop_acc  = pop & ~empty_q & ~flush;
    rd_word  = mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_acc) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrOne;
      if (pop_acc)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrOne;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Status flags are registered from the next occupancy so they line up with count.
  always_comb begin
    full_d   = (count_d == SizeCnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfCnt);
    aempty_d = (count_d <= AeCnt);
  end

  always_comb begin
    overflow_d  = overflow_q | (push & full_q & ~flush);
    underflow_d = underflow_q | (pop & empty_q & ~flush);
    dout_d      = pop_acc ? rd_word : dout_q;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge ck) begin
    if (!rst && push_acc) begin
      mem_q[wr_ptr_q] <= dataIn;
    end
  end

  // In FWFT mode the head word is shown directly; the last popped word covers the empty case.
  always_comb begin
    if (FWFT) begin
      dataOut = empty_q ? dout_q : rd_word;
    end else begin
      dataOut = dout_q;
    end
    full        = full_q;
    empty       = empty_q;
    almostFull  = afull_q;
    almostEmpty = aempty_q;
    count       = count_q;
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

endmodule

// File: tb/tb_ck_sync_fifo.sv
// Bench for ck_sync_fifo: one standard and one FWFT instance driven in lock-step,
// compared against directed vectors and a queue-based reference model.
module tb_ck_sync_fifo;

  localparam int unsigned Size = 5;

  logic       ck = 1'b0;
  logic       rst = 1'b1, flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] dataIn = 8'h00;

  logic       full0, afull0, empty0, aempty0, ovf0, udf0;
  logic       full1, afull1, empty1, aempty1, ovf1, udf1;
  logic [7:0] dout0, dout1;
  logic [2:0] cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf = 1'b0, m_udf = 1'b0;

  always #5 ck = ~ck;

  ck_sync_fifo #(.DATA_W(8), .FIFO_SIZE(Size), .FWFT(1'b0), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut0 (
    .ck(ck), .rst(rst), .flush(flush), .push(push), .dataIn(dataIn), .full(full0),
    .almostFull(afull0), .pop(pop), .dataOut(dout0), .empty(empty0), .almostEmpty(aempty0),
    .count(cnt0), .overflow(ovf0), .underflow(udf0)
  );

  ck_sync_fifo #(.DATA_W(8), .FIFO_SIZE(Size), .FWFT(1'b1), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut1 (
    .ck(ck), .rst(rst), .flush(flush), .push(push), .dataIn(dataIn), .full(full1),
    .almostFull(afull1), .pop(pop), .dataOut(dout1), .empty(empty1), .almostEmpty(aempty1),
    .count(cnt1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input logic r, f, pu, po, input logic [7:0] d);
    int sz;
    sz = q.size();
    if (r) begin
      q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (f) begin
      q.delete();
    end else begin
      if (pu && sz == Size) m_ovf = 1'b1;
      if (po && sz == 0) m_udf = 1'b1;
      if (po && sz != 0) m_dout = q.pop_front();
      if (pu && sz != Size) q.push_back(d);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    chk("m_count0", int'(cnt0), sz);
    chk("m_empty0", int'(empty0), int'(sz == 0));
    chk("m_full0", int'(full0), int'(sz == Size));
    chk("m_afull0", int'(afull0), int'(sz >= 4));
    chk("m_aempty0", int'(aempty0), int'(sz <= 1));
    chk("m_ovf0", int'(ovf0), int'(m_ovf));
    chk("m_udf0", int'(udf0), int'(m_udf));
    chk("m_dout0", int'(dout0), int'(m_dout));
    chk("m_count1", int'(cnt1), sz);
    chk("m_empty1", int'(empty1), int'(sz == 0));
    chk("m_full1", int'(full1), int'(sz == Size));
    chk("m_afull1", int'(afull1), int'(sz >= 4));
    chk("m_aempty1", int'(aempty1), int'(sz <= 1));
    chk("m_ovf1", int'(ovf1), int'(m_ovf));
    chk("m_udf1", int'(udf1), int'(m_udf));
    if (sz != 0) chk("m_dout1_head", int'(dout1), int'(q[0]));
  endtask

  task automatic step(input logic r, f, pu, po, input logic [7:0] d);
    rst    = r;
    flush  = f;
    push   = pu;
    pop    = po;
    dataIn = d;
    @(posedge ck);
    model_update(r, f, pu, po, d);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       r, f, pu, po;
    logic [7:0] d;
    int         cnt;
    logic       emp, ful;
    logic [7:0] dout;
    logic       ovf, udf;
  } vec_t;

  localparam int NVec = 21;
  vec_t tv[NVec];

  initial begin
    // Expected values are for the standard (latency-1) instance.
    //          r     f     pu    po    din     cnt emp   ful   dout    ovf   udf
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 5, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0};
    tv[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0};
    tv[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1};
    tv[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1};
    tv[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 2, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1};
    tv[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h88, 3, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1};
    tv[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1};
    tv[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tv[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < NVec; i++) begin
      step(tv[i].r, tv[i].f, tv[i].pu, tv[i].po, tv[i].d);
      chk($sformatf("tv%0d_count", i), int'(cnt0), tv[i].cnt);
      chk($sformatf("tv%0d_empty", i), int'(empty0), int'(tv[i].emp));
      chk($sformatf("tv%0d_full", i), int'(full0), int'(tv[i].ful));
      chk($sformatf("tv%0d_afull", i), int'(afull0), int'(tv[i].cnt >= 4));
      chk($sformatf("tv%0d_aempty", i), int'(aempty0), int'(tv[i].cnt <= 1));
      chk($sformatf("tv%0d_dout", i), int'(dout0), int'(tv[i].dout));
      chk($sformatf("tv%0d_ovf", i), int'(ovf0), int'(tv[i].ovf));
      chk($sformatf("tv%0d_udf", i), int'(udf0), int'(tv[i].udf));
    end

    // FWFT: first word is visible the cycle after its push.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
    chk("fwft_first_empty", int'(empty1), 0);
    chk("fwft_first_dout", int'(dout1), 8'hC3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
    chk("fwft_next_dout", int'(dout1), 8'h3C);
    chk("std_pop_dout", int'(dout0), 8'hC3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Wrap: 4 rounds of push 3 / pop 3 walk the pointers past the last slot.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h30 + r * 3 + k));
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("wrap_dout", int'(dout0), 8'h30 + r * 3 + k);
      end
    end
    chk("wrap_no_ovf", int'(ovf0 | ovf1), 0);
    chk("wrap_no_udf", int'(udf0 | udf1), 0);

    // Concurrent push+pop at count 2 holds occupancy.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h03 + k));
      chk("conc_count", int'(cnt0), 2);
      chk("conc_dout", int'(dout0), 8'h01 + k);
    end
    // Fill, then push+pop on full pops only and flags overflow.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'hB0 + k));
    chk("conc_full", int'(full0), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
    chk("conc_full_count", int'(cnt0), 4);
    chk("conc_full_ovf", int'(ovf0), 1);

    // Randomised traffic with alternating push/pop bias, rare flush and reset.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = ((i / 100) % 2 == 0) ? 70 : 30;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < (100 - bias)),
           8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
